sha256_job_arbiter: RTL

Shares one `simplified_sha256` core between NUM_REQ independent requesters. Each requester posts a message address and a hash destination address. The arbiter selects one requester per job using round-robin and sequences the core's start/done handshake. When the hash is written back, it returns a per-requester completion pulse. It sits between the requester masters and the core's `start`/`input_addr`/`hash_addr`/`done` pins; the core keeps its own memory port.

---
 rtl/sha256_job_arbiter_pkg.sv | 40 ++++
 rtl/sha256_job_arbiter_rr_arbiter.sv | 35 +++
 rtl/sha256_job_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sha256_job_arbiter_pkg.sv
// sha256_arb_pkg: shared types and helpers for the SHA-256 job arbiter.
//   arb_state_t : arbiter FSM states
//   ADDR_W_DEF  : default word-address width (matches the core)
//   MAX_REQ     : widest requester vector rr_pick can handle
//   rr_pick()   : round-robin pick, first set bit at or above ptr, wrapping at n
package sha256_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned MAX_REQ    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINISH
    } arb_state_t;

    // Returns a one-hot winner (all zero when req is empty). The wrap is an
    // explicit compare against n so non-power-of-two requester counts work.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [2:0]         ptr,
                                                   input int unsigned        n);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        idx   = 32'(ptr);
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found && req[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
            idx = (idx + 1 >= n) ? 0 : idx + 1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/sha256_job_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index for this pick
//   grant : one-hot winner
//   idx   : binary index of the winner
//   valid : a winner exists
module rr_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick                   = rr_pick(req_ext, 3'(ptr), NUM_REQ);
        grant                  = pick[NUM_REQ-1:0];
        valid                  = |pick;
        idx                    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/sha256_job_arbiter.sv
// sha256_job_arbiter: shares one simplified_sha256 core between NUM_REQ
// requesters using round-robin and sequences the core start/done handshake.
//   clk, rst (async, active-high)
//   req / req_input_addr / req_hash_addr : per-requester job posts
//   req_grant / req_done                 : one-hot 1-cycle acknowledge pulses
//   busy, cur_id                         : job status
//   core_start / core_input_addr / core_hash_addr / core_done : core side
// Build option: SHA_ARB_PRIO0_EN gives requester 0 strict priority, and the
// round-robin pointer is left untouched after serving it.
module sha256_job_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_input_addr,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_hash_addr,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    cur_id,
    output logic                          core_start,
    output logic [ADDR_W-1:0]             core_input_addr,
    output logic [ADDR_W-1:0]             core_hash_addr,
    input  logic                          core_done
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   cur_id_q, cur_id_d;
    logic [ADDR_W-1:0]  in_addr_q, in_addr_d;
    logic [ADDR_W-1:0]  hash_addr_q, hash_addr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_id;
    logic [ADDR_W-1:0]  win_in_addr;
    logic [ADDR_W-1:0]  win_hash_addr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
`ifdef SHA_ARB_PRIO0_EN
        if (req[0]) begin
            win_onehot = NUM_REQ'(1);
            win_id     = '0;
        end else begin
            win_onehot = pick_grant;
            win_id     = pick_idx;
        end
`else
        win_onehot = pick_grant;
        win_id     = pick_idx;
`endif
        win_in_addr   = '0;
        win_hash_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDX_W'(i)) begin
                win_in_addr   = req_input_addr[i*ADDR_W +: ADDR_W];
                win_hash_addr = req_hash_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        in_addr_d   = in_addr_q;
        hash_addr_d = hash_addr_q;
        grant_d     = '0;
        done_d      = '0;
        start_d     = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                // Grant/start are registered, so they are raised on the edge
                // leaving IDLE and are visible for exactly the START cycle.
                if (core_done && pick_valid) begin
                    cur_id_d    = win_id;
                    in_addr_d   = win_in_addr;
                    hash_addr_d = win_hash_addr;
                    grant_d     = win_onehot;
                    start_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!core_done) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    done_d[cur_id_q] = 1'b1;
                    busy_d           = 1'b0;
                    state_d          = S_FINISH;
                end
            end
            S_FINISH: begin
`ifdef SHA_ARB_PRIO0_EN
                if (cur_id_q != '0)
                    rr_ptr_d = (cur_id_q == IDX_W'(NUM_REQ-1)) ? '0 : cur_id_q + 1'b1;
`else
                rr_ptr_d = (cur_id_q == IDX_W'(NUM_REQ-1)) ? '0 : cur_id_q + 1'b1;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            in_addr_q   <= '0;
            hash_addr_q <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            in_addr_q   <= in_addr_d;
            hash_addr_q <= hash_addr_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign req_grant       = grant_q;
    assign req_done        = done_q;
    assign busy            = busy_q;
    assign cur_id          = cur_id_q;
    assign core_start      = start_q;
    assign core_input_addr = in_addr_q;
    assign core_hash_addr  = hash_addr_q;

endmodule
